// File: rtl/vga_timing_engine.sv
`default_nettype none
// ============================================================================
// Module : vga_timing_engine
// Brief  : VGA/DAC timing generator and pixel formatter fed from a fixed-latency frame-buffer pull port.
// Rev    : 1.0
// ============================================================================
module vga_timing_engine #(
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter logic SYNC_POL = 1'b0,
   parameter int   IN_FMT   = 0,
   parameter int   COLOR_W  = 8,
   parameter int   RD_LAT   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         mode,
   input  logic               ufl_clr,
   input  logic [23:0]        din,
   input  logic               din_vld,
   output logic               req,
   output logic [COLOR_W-1:0] vga_r,
   output logic [COLOR_W-1:0] vga_g,
   output logic [COLOR_W-1:0] vga_b,
   output logic               vga_blank_n,
   output logic               vga_sync_n,
   output logic               vga_clk,
   output logic               hsync,
   output logic               vsync,
   output logic               frame_start,
   output logic               ufl_flag,
   output logic [15:0]        ufl_cnt
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int H_START = H_SYNC + H_BP;
   localparam int H_END   = H_START + H_ACTIVE;
   localparam int V_START = V_SYNC + V_BP;
   localparam int V_END   = V_START + V_ACTIVE;
   localparam int BAR_W   = H_ACTIVE / 8;
   localparam int BPW     = $clog2(BAR_W + 1);
   localparam int SRC_R_W = (IN_FMT == 1) ? 8 : 5;
   localparam int SRC_G_W = (IN_FMT == 1) ? 8 : 6;
   localparam int SRC_B_W = (IN_FMT == 1) ? 8 : 5;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       de;
      logic       fs;
      logic [1:0] md;
      logic [2:0] bar;
      logic       grid;
   } tinfo_t;

   logic [HW-1:0]      h_cnt_q, h_cnt_d;
   logic [VW-1:0]      v_cnt_q, v_cnt_d;
   logic [1:0]         frame_mode_q, frame_mode_d;
   logic [BPW-1:0]     bar_pix_q, bar_pix_d;
   logic [2:0]         bar_idx_q, bar_idx_d;
   logic               active_h, active_v;
   logic [4:0]         x_lo, y_lo;
   tinfo_t             line_q [RD_LAT];
   tinfo_t             line_d [RD_LAT];
   tinfo_t             tap;
   logic               ufl_evt;
   logic [COLOR_W-1:0] vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;
   logic               blank_n_q, blank_n_d, hsync_q, hsync_d, vsync_q, vsync_d;
   logic               fs_q, fs_d, ufl_flag_q, ufl_flag_d;
   logic [15:0]        ufl_cnt_q, ufl_cnt_d;
   logic [SRC_R_W-1:0] src_r;
   logic [SRC_G_W-1:0] src_g;
   logic [SRC_B_W-1:0] src_b;
   logic [COLOR_W-1:0] exp_r, exp_g, exp_b;

   generate
      if (IN_FMT == 1) begin : g_fmt888
         assign src_r = din[23:16];
         assign src_g = din[15:8];
         assign src_b = din[7:0];
      end else begin : g_fmt565
         logic din_unused;
         assign din_unused = ^din[23:16];
         assign src_r = din[15:11];
         assign src_g = din[10:5];
         assign src_b = din[4:0];
      end
   endgenerate

   // Left-align each channel and refill low bits by cycling its MSBs; narrower DACs keep only the MSBs.
   generate
      for (genvar i = 0; i < COLOR_W; i++) begin : g_expand
         assign exp_r[COLOR_W-1-i] = src_r[SRC_R_W-1-(i % SRC_R_W)];
         assign exp_g[COLOR_W-1-i] = src_g[SRC_G_W-1-(i % SRC_G_W)];
         assign exp_b[COLOR_W-1-i] = src_b[SRC_B_W-1-(i % SRC_B_W)];
      end
   endgenerate

   always_comb begin
      active_h = (h_cnt_q >= HW'(H_START)) && (h_cnt_q < HW'(H_END));
      active_v = (v_cnt_q >= VW'(V_START)) && (v_cnt_q < VW'(V_END));
      req      = active_h && active_v && (frame_mode_q == 2'd0);
      x_lo     = 5'(h_cnt_q - HW'(H_START));
      y_lo     = 5'(v_cnt_q - VW'(V_START));

      h_cnt_d = (h_cnt_q == HW'(H_TOTAL - 1)) ? '0 : h_cnt_q + HW'(1);
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == HW'(H_TOTAL - 1)) begin
         v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + VW'(1);
      end
      frame_mode_d = ((h_cnt_q == '0) && (v_cnt_q == '0)) ? mode : frame_mode_q;

      // Bar tracker is aligned to the counter value it will hold next cycle.
      if (h_cnt_d == HW'(H_START)) begin
         bar_pix_d = '0;
         bar_idx_d = '0;
      end else if (bar_pix_q == BPW'(BAR_W - 1)) begin
         bar_pix_d = '0;
         bar_idx_d = bar_idx_q + 3'd1;
      end else begin
         bar_pix_d = bar_pix_q + BPW'(1);
         bar_idx_d = bar_idx_q;
      end

      line_d[0].hs   = h_cnt_q < HW'(H_SYNC);
      line_d[0].vs   = v_cnt_q < VW'(V_SYNC);
      line_d[0].de   = active_h && active_v;
      line_d[0].fs   = (h_cnt_q == '0) && (v_cnt_q == '0);
      line_d[0].md   = frame_mode_q;
      line_d[0].bar  = bar_idx_q;
      line_d[0].grid = (x_lo == 5'd0) || (y_lo == 5'd0);
      for (int i = 1; i < RD_LAT; i++) begin
         line_d[i] = line_q[i-1];
      end
   end

   always_comb begin
      tap     = line_q[RD_LAT-1];
      ufl_evt = tap.de && (tap.md == 2'd0) && !din_vld;
      vga_r_d = '0;
      vga_g_d = '0;
      vga_b_d = '0;
      if (tap.de) begin
         case (tap.md)
            2'd0: begin
               if (din_vld) begin
                  vga_r_d = exp_r;
                  vga_g_d = exp_g;
                  vga_b_d = exp_b;
               end
            end
            2'd1: begin
               vga_r_d = {COLOR_W{~tap.bar[1]}};
               vga_g_d = {COLOR_W{~tap.bar[2]}};
               vga_b_d = {COLOR_W{~tap.bar[0]}};
            end
            2'd2: begin
               if (tap.grid) begin
                  vga_r_d = '1;
                  vga_g_d = '1;
                  vga_b_d = '1;
               end
            end
            default: begin
            end
         endcase
      end
      blank_n_d  = tap.de;
      hsync_d    = tap.hs ? SYNC_POL : ~SYNC_POL;
      vsync_d    = tap.vs ? SYNC_POL : ~SYNC_POL;
      fs_d       = tap.fs;
      ufl_flag_d = ufl_clr ? 1'b0 : (ufl_flag_q | ufl_evt);
      ufl_cnt_d  = ufl_clr ? 16'd0 :
                   (ufl_evt && (ufl_cnt_q != 16'hFFFF)) ? ufl_cnt_q + 16'd1 : ufl_cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt_q      <= '0;
         v_cnt_q      <= '0;
         frame_mode_q <= 2'd0;
         bar_pix_q    <= '0;
         bar_idx_q    <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            line_q[i] <= '0;
         end
         vga_r_q      <= '0;
         vga_g_q      <= '0;
         vga_b_q      <= '0;
         blank_n_q    <= 1'b0;
         hsync_q      <= ~SYNC_POL;
         vsync_q      <= ~SYNC_POL;
         fs_q         <= 1'b0;
         ufl_flag_q   <= 1'b0;
         ufl_cnt_q    <= 16'd0;
      end else begin
         h_cnt_q      <= h_cnt_d;
         v_cnt_q      <= v_cnt_d;
         frame_mode_q <= frame_mode_d;
         bar_pix_q    <= bar_pix_d;
         bar_idx_q    <= bar_idx_d;
         for (int i = 0; i < RD_LAT; i++) begin
            line_q[i] <= line_d[i];
         end
         vga_r_q      <= vga_r_d;
         vga_g_q      <= vga_g_d;
         vga_b_q      <= vga_b_d;
         blank_n_q    <= blank_n_d;
         hsync_q      <= hsync_d;
         vsync_q      <= vsync_d;
         fs_q         <= fs_d;
         ufl_flag_q   <= ufl_flag_d;
         ufl_cnt_q    <= ufl_cnt_d;
      end
   end

   assign vga_r       = vga_r_q;
   assign vga_g       = vga_g_q;
   assign vga_b       = vga_b_q;
   assign vga_blank_n = blank_n_q;
   assign vga_sync_n  = 1'b0;
   assign vga_clk     = ~clk;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign frame_start = fs_q;
   assign ufl_flag    = ufl_flag_q;
   assign ufl_cnt     = ufl_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_timing_engine
// Brief  : Directed self-checking bench for vga_timing_engine in a 24x8 small mode.
// Rev    : 1.0
// ============================================================================
module tb_vga_timing_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  mode;
   logic        ufl_clr;
   logic [23:0] din;
   logic        din_vld;
   logic        req;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        vga_blank_n, vga_sync_n, vga_clk, hsync, vsync, frame_start, ufl_flag;
   logic [15:0] ufl_cnt;

   int n_cmp = 0;
   int n_err = 0;
   bit drop_req;

   vga_timing_engine #(
      .H_SYNC(4), .H_BP(2), .H_ACTIVE(16), .H_FP(2),
      .V_SYNC(2), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
      .SYNC_POL(1'b0), .IN_FMT(0), .COLOR_W(8), .RD_LAT(2)
   ) dut (
      .clk(clk), .rst(rst), .mode(mode), .ufl_clr(ufl_clr), .din(din), .din_vld(din_vld),
      .req(req), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_blank_n(vga_blank_n),
      .vga_sync_n(vga_sync_n), .vga_clk(vga_clk), .hsync(hsync), .vsync(vsync),
      .frame_start(frame_start), .ufl_flag(ufl_flag), .ufl_cnt(ufl_cnt)
   );

   always #5 clk = ~clk;

   // Upstream model: answers each request two cycles later; can swallow three answers on demand.
   initial begin
      bit p0, p1, armed;
      int drop_left;
      p0 = 1'b0; p1 = 1'b0; armed = 1'b0; drop_left = 0;
      din_vld = 1'b0;
      forever begin
         @(posedge clk or posedge rst);
         #1;
         if (rst) begin
            p0 = 1'b0; p1 = 1'b0; din_vld = 1'b0;
         end else begin
            if (drop_req && !armed) begin
               drop_left = 3;
               armed = 1'b1;
            end
            if (p1 && drop_left > 0) begin
               din_vld = 1'b0;
               drop_left--;
            end else begin
               din_vld = p1;
            end
            p1 = p0;
            p0 = req;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic bit act(input int s);
      int h, v;
      h = s % 24;
      v = (s / 24) % 8;
      return (h >= 6) && (h < 22) && (v >= 3) && (v < 7);
   endfunction

   function automatic int fm(input int f);
      case (f)
         1: return 3;
         2: return 1;
         3: return 2;
         default: return 0;
      endcase
   endfunction

   function automatic logic [23:0] bar_rgb(input int x);
      case (x / 2)
         0: return 24'hFFFFFF;
         1: return 24'hFFFF00;
         2: return 24'h00FFFF;
         3: return 24'h00FF00;
         4: return 24'hFF00FF;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   task automatic check_reset_state();
      check("rst_req",     32'(req),             32'd0);
      check("rst_blank_n", 32'(vga_blank_n),     32'd0);
      check("rst_rgb",     32'({vga_r, vga_g, vga_b}), 32'd0);
      check("rst_hsync",   32'(hsync),           32'd1);
      check("rst_vsync",   32'(vsync),           32'd1);
      check("rst_fs",      32'(frame_start),     32'd0);
      check("rst_ufl",     32'(ufl_flag),        32'd0);
      check("rst_ufl_cnt", 32'(ufl_cnt),         32'd0);
   endtask

   // k = rising edges since reset release; pins show counter state k-3.
   task automatic check_cycle(input int k);
      int s, cnt;
      bit de, hs_n, vs_n, fs;
      logic [23:0] rgb;
      check("req", 32'(req), (act(k) && fm(k / 192) == 0) ? 32'd1 : 32'd0);
      de = 1'b0; hs_n = 1'b1; vs_n = 1'b1; fs = 1'b0; rgb = 24'h0; cnt = 0;
      if (k >= 3) begin
         s    = k - 3;
         de   = act(s);
         hs_n = (s % 24) >= 4;
         vs_n = ((s / 24) % 8) >= 2;
         fs   = (s % 192) == 0;
         if (de) begin
            case (fm(s / 192))
               0: rgb = (s >= 870 && s <= 872) ? 24'h000000 : 24'hFF0000;
               1: rgb = bar_rgb(s % 24 - 6);
               2: rgb = (((s % 24 - 6) % 32 == 0) || (((s / 24) % 8 - 3) % 32 == 0)) ?
                        24'hFFFFFF : 24'h000000;
               default: rgb = 24'h000000;
            endcase
         end
         if (k < 951) begin
            for (int d = 870; d <= 872; d++) begin
               if (d <= s) cnt++;
            end
         end
      end
      check("blank_n",  32'(vga_blank_n), 32'(de));
      check("hsync",    32'(hsync),       32'(hs_n));
      check("vsync",    32'(vsync),       32'(vs_n));
      check("frame_st", 32'(frame_start), 32'(fs));
      check("rgb",      32'({vga_r, vga_g, vga_b}), 32'(rgb));
      check("ufl_cnt",  32'(ufl_cnt),     32'(cnt));
      check("ufl_flag", 32'(ufl_flag),    (cnt > 0) ? 32'd1 : 32'd0);
      check("sync_n",   32'(vga_sync_n),  32'd0);
      check("vga_clk",  32'(vga_clk),     32'd1);
   endtask

   initial begin
      int req_f0, req_f4;
      req_f0 = 0; req_f4 = 0;
      rst = 1'b1; mode = 2'd0; ufl_clr = 1'b0; din = 24'h00F800; drop_req = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state();
      rst = 1'b0;

      // Frames: 0 stream, 1 black, 2 bars, 3 grid, 4 stream with three dropped answers, 5 stream.
      for (int k = 1; k <= 1042; k++) begin
         @(negedge clk);
         check_cycle(k);
         if (req && (k / 192) == 0) req_f0++;
         if (req && (k / 192) == 4) req_f4++;
         case (k)
            100: mode = 2'd3;
            300: mode = 2'd1;
            500: mode = 2'd2;
            700: mode = 2'd0;
            864: drop_req = 1'b1;
            950: ufl_clr = 1'b1;
            951: ufl_clr = 1'b0;
            default: begin
            end
         endcase
      end
      check("req_frame0", 32'(req_f0), 32'd64);
      check("req_frame4", 32'(req_f4), 32'd64);

      // Reset while an active pixel is on the pins.
      check("pre_rst_blank", 32'(vga_blank_n), 32'd1);
      rst = 1'b1;
      #1;
      check_reset_state();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         check_cycle(k);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
